input_port_ydma: RTL and testbench



---
 rtl/input_port_ydma_pkg.sv | 31 +++
 rtl/input_port_ydma_if.sv | 24 ++
 rtl/input_port_ydma_bram_fifo.sv | 78 +++++++
 rtl/input_port_ydma.sv | 123 ++++++++++++
 tb/tb_input_port_ydma.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/input_port_ydma_pkg.sv
// Shared leaf-interface packet definitions, used by input_port_ydma and the
// output-port packetiser.
// Packet layout (MSB first): valid | dst_leaf | dst_port | zero pad |
// credit flag (bit PAYLOAD_BITS) | payload.
package input_port_ydma_pkg;
  localparam int PACKET_BITS_DEF           = 97;
  localparam int NUM_LEAF_BITS_DEF         = 6;
  localparam int NUM_PORT_BITS_DEF         = 4;
  localparam int PAYLOAD_BITS_DEF          = 64;
  localparam int NUM_BRAM_ADDR_BITS_DEF    = 7;
  localparam int FREESPACE_UPDATE_SIZE_DEF = 64;

  typedef enum logic {CR_IDLE = 1'b0, CR_SEND = 1'b1} credit_state_e;

  function automatic int valid_bit(int pkt_bits);
    return pkt_bits - 1;
  endfunction

  function automatic int leaf_lsb(int pkt_bits, int leaf_bits);
    return pkt_bits - 1 - leaf_bits;
  endfunction

  function automatic int port_lsb(int pkt_bits, int leaf_bits, int port_bits);
    return pkt_bits - 1 - leaf_bits - port_bits;
  endfunction

  // The credit flag sits directly above the payload.
  function automatic int credit_bit(int payload_bits);
    return payload_bits;
  endfunction
endpackage

// File: rtl/input_port_ydma_if.sv
// Handshake bundle of input_port_ydma: credit packet channel to the network
// and the payload valid/ack channel to the user operator.
// master: the input port (drives credit_out*, dout, vld).
// slave : network + operator side (drives credit_out_ack, ack).
interface input_port_ydma_if #(
  parameter int PACKET_BITS  = 97,
  parameter int PAYLOAD_BITS = 64
);
  logic [PACKET_BITS-1:0]  credit_out;
  logic                    credit_out_vld;
  logic                    credit_out_ack;
  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;

  modport master (
    output credit_out, credit_out_vld, dout_leaf_interface2user, vld_interface2user,
    input  credit_out_ack, ack_user2interface
  );
  modport slave (
    input  credit_out, credit_out_vld, dout_leaf_interface2user, vld_interface2user,
    output credit_out_ack, ack_user2interface
  );
endinterface

// File: rtl/input_port_ydma_bram_fifo.sv
// ydma_bram_fifo: BRAM circular buffer with registered read and a one-entry
// show-ahead output register.
// Ports: clk, rst (async high); wr_en_i/wr_data_i write request (dropped when
// full unless a read frees a slot the same cycle); rd_ack_i user ack;
// dout_o/vld_o show-ahead word; xfer_o user transfer; full_o/empty_o.
// Occupancy counts every word not yet handed to the user, including the two
// words that may sit in the read pipeline.
module ydma_bram_fifo #(
  parameter int AW = 7,
  parameter int PW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [PW-1:0] wr_data_i,
  input  logic          rd_ack_i,
  output logic [PW-1:0] dout_o,
  output logic          vld_o,
  output logic          xfer_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, occ_d, unread;
  logic          s1_vld_q, s2_vld_q;
  logic [PW-1:0] s1_q, s2_q;
  logic          do_wr, s2_load, rd_en;

  assign full_o  = (occ_q == (AW+1)'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign xfer_o  = s2_vld_q & rd_ack_i;
  // A transfer on a full FIFO frees a slot in time for the incoming word.
  assign do_wr   = wr_en_i & (~full_o | xfer_o);
  // Words still in BRAM, not yet pulled into the read pipeline.
  assign unread  = occ_q - (AW+1)'(s1_vld_q) - (AW+1)'(s2_vld_q);
  assign s2_load = s1_vld_q & (~s2_vld_q | xfer_o);
  assign rd_en   = (unread != '0) & (~s1_vld_q | s2_load);
  assign occ_d   = occ_q + (AW+1)'(do_wr) - (AW+1)'(xfer_o);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_vld_q <= 1'b0;
      s2_q     <= '0;
    end else begin
      occ_q <= occ_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) begin
        s1_q     <= mem[rd_ptr_q];
        s1_vld_q <= 1'b1;
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else if (s2_load) begin
        s1_vld_q <= 1'b0;
      end
      if (s2_load) begin
        s2_q     <= s1_q;
        s2_vld_q <= 1'b1;
      end else if (xfer_o) begin
        s2_vld_q <= 1'b0;
      end
    end
  end

  assign dout_o = s2_q;
  assign vld_o  = s2_vld_q;
endmodule

// File: rtl/input_port_ydma.sv
// input_port_ydma: receive side of the leaf-interface packet protocol.
// Ports: clk, reset (async high); in_control_reg {enable, src_leaf, src_port};
// self_leaf; din_leaf_bft2interface incoming packet; bus (master) carries
// the credit channel and the user payload channel; overflow sticky drop flag.
// Accepted payloads go into ydma_bram_fifo; every FREESPACE_UPDATE_SIZE
// consumed words a credit packet is sent back to {src_leaf, src_port}.
module input_port_ydma
  import input_port_ydma_pkg::*;
#(
  parameter int PACKET_BITS           = PACKET_BITS_DEF,
  parameter int NUM_LEAF_BITS         = NUM_LEAF_BITS_DEF,
  parameter int NUM_PORT_BITS         = NUM_PORT_BITS_DEF,
  parameter int PAYLOAD_BITS          = PAYLOAD_BITS_DEF,
  parameter int NUM_BRAM_ADDR_BITS    = NUM_BRAM_ADDR_BITS_DEF,
  parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_SIZE_DEF,
  parameter int PORT_ID               = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS:0] in_control_reg,
  input  logic [NUM_LEAF_BITS-1:0]             self_leaf,
  input  logic [PACKET_BITS-1:0]               din_leaf_bft2interface,
  input_port_ydma_if.master                    bus,
  output logic                                 overflow
);
  localparam int VLD_B = valid_bit(PACKET_BITS);
  localparam int LF_L  = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
  localparam int PT_L  = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int CR_B  = credit_bit(PAYLOAD_BITS);
  localparam int CW    = NUM_BRAM_ADDR_BITS + 1;

  logic                     enable;
  logic [NUM_LEAF_BITS-1:0] src_leaf;
  logic [NUM_PORT_BITS-1:0] src_port;
  logic                     accept, full, empty, xfer, overflow_q;
  logic [PAYLOAD_BITS-1:0]  fifo_dout;
  logic                     fifo_vld;
  logic                     unused_ok;

  assign {enable, src_leaf, src_port} = in_control_reg;

  assign accept = din_leaf_bft2interface[VLD_B] & enable
                & (din_leaf_bft2interface[LF_L +: NUM_LEAF_BITS] == self_leaf)
                & (din_leaf_bft2interface[PT_L +: NUM_PORT_BITS] == NUM_PORT_BITS'(PORT_ID))
                & ~din_leaf_bft2interface[CR_B];

  assign unused_ok = ^{din_leaf_bft2interface[PT_L-1:CR_B+1], empty};

  ydma_bram_fifo #(.AW(NUM_BRAM_ADDR_BITS), .PW(PAYLOAD_BITS)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .wr_en_i   (accept),
    .wr_data_i (din_leaf_bft2interface[PAYLOAD_BITS-1:0]),
    .rd_ack_i  (bus.ack_user2interface),
    .dout_o    (fifo_dout),
    .vld_o     (fifo_vld),
    .xfer_o    (xfer),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.dout_leaf_interface2user = fifo_dout;
  assign bus.vld_interface2user       = fifo_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       overflow_q <= 1'b0;
    else if (accept & full & ~xfer)  overflow_q <= 1'b1;
  end
  assign overflow = overflow_q;

  // Credit FSM
  credit_state_e          state_q, state_d;
  logic [CW-1:0]          consumed_q, consumed_d;
  logic [PACKET_BITS-1:0] credit_q, credit_d, credit_pkt;

  always_comb begin
    credit_pkt = '0;
    credit_pkt[VLD_B]                = 1'b1;
    credit_pkt[LF_L +: NUM_LEAF_BITS] = src_leaf;
    credit_pkt[PT_L +: NUM_PORT_BITS] = src_port;
    credit_pkt[CR_B]                 = 1'b1;
    credit_pkt[PAYLOAD_BITS-1:0]     = PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE);
  end

  always_comb begin
    state_d    = state_q;
    consumed_d = consumed_q + CW'(xfer);
    credit_d   = credit_q;
    case (state_q)
      CR_IDLE: begin
        // Compare against the post-transfer count so the credit goes out
        // the cycle right after the threshold transfer.
        if (consumed_d >= CW'(FREESPACE_UPDATE_SIZE)) begin
          state_d  = CR_SEND;
          credit_d = credit_pkt;
        end
      end
      CR_SEND: begin
        if (bus.credit_out_ack) begin
          state_d    = CR_IDLE;
          consumed_d = consumed_q + CW'(xfer) - CW'(FREESPACE_UPDATE_SIZE);
          credit_d   = '0;
        end
      end
      default: state_d = CR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CR_IDLE;
      consumed_q <= '0;
      credit_q   <= '0;
    end else begin
      state_q    <= state_d;
      consumed_q <= consumed_d;
      credit_q   <= credit_d;
    end
  end

  assign bus.credit_out     = credit_q;
  assign bus.credit_out_vld = (state_q == CR_SEND);
endmodule

// File: tb/tb_input_port_ydma.sv
module tb_input_port_ydma;
  localparam int PB = 97, NL = 6, NP = 4, PW = 64, AW = 7;
  localparam int DEPTH = 128, FUS = 64, PORT = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NL+NP:0] ctrl;
  logic [NL-1:0]  self_leaf;
  logic [PB-1:0]  din;
  logic           overflow;

  input_port_ydma_if #(.PACKET_BITS(PB), .PAYLOAD_BITS(PW)) bus();

  always #5 clk = ~clk;

  input_port_ydma #(
    .PACKET_BITS(PB), .NUM_LEAF_BITS(NL), .NUM_PORT_BITS(NP), .PAYLOAD_BITS(PW),
    .NUM_BRAM_ADDR_BITS(AW), .FREESPACE_UPDATE_SIZE(FUS), .PORT_ID(PORT)
  ) dut (
    .clk(clk), .reset(reset), .in_control_reg(ctrl), .self_leaf(self_leaf),
    .din_leaf_bft2interface(din), .bus(bus), .overflow(overflow)
  );

  typedef struct { logic [PW-1:0] data; int w; } ent_t;

  ent_t q[$];
  int   cyc = 0, checks = 0, errors = 0, m_cons = 0;
  bit   m_send = 0, m_ovf = 0, en = 1;
  logic [NL-1:0] src_leaf = 6'h2A;
  logic [NP-1:0] src_port = 4'h9;
  logic [PB-1:0] exp_credit, saved;

  function automatic logic [PB-1:0] mk(bit v, int lf, int pt, bit cf, logic [PW-1:0] pl);
    logic [PB-1:0] p;
    p = '0;
    p[PB-1] = v;
    p[PB-2 -: NL] = NL'(lf);
    p[PB-2-NL -: NP] = NP'(pt);
    p[PW] = cf;
    p[PW-1:0] = pl;
    return p;
  endfunction

  function automatic logic [PB-1:0] good(logic [PW-1:0] pl);
    return mk(1'b1, 5, PORT, 1'b0, pl);
  endfunction

  // A stored word is visible once it heads the queue and two edges have
  // passed since the edge that wrote it.
  function automatic bit m_vld();
    return (q.size() > 0) && (cyc >= q[0].w + 2);
  endfunction

  task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("vld", PB'(bus.vld_interface2user), PB'(m_vld()));
    if (m_vld()) chk("dout", PB'(bus.dout_leaf_interface2user), PB'(q[0].data));
    chk("credit_vld", PB'(bus.credit_out_vld), PB'(m_send));
    if (m_send) chk("credit_out", bus.credit_out, exp_credit);
    chk("overflow", PB'(overflow), PB'(m_ovf));
  endtask

  task automatic step(input logic [PB-1:0] pkt, input bit ack, input bit cack);
    bit xfer, match, full;
    ent_t e;
    ctrl = {en, src_leaf, src_port};
    din = pkt;
    bus.ack_user2interface = ack;
    bus.credit_out_ack = cack;
    xfer  = m_vld() && ack;
    match = pkt[PB-1] && en && (pkt[PB-2 -: NL] == NL'(5)) &&
            (pkt[PB-2-NL -: NP] == NP'(PORT)) && !pkt[PW];
    full  = (q.size() == DEPTH) && !xfer;
    @(posedge clk); #1;
    cyc++;
    if (xfer) void'(q.pop_front());
    if (match) begin
      if (full) m_ovf = 1;
      else begin
        e.data = pkt[PW-1:0];
        e.w = cyc;
        q.push_back(e);
      end
    end
    if (!m_send) begin
      m_cons += int'(xfer);
      if (m_cons >= FUS) m_send = 1;
    end else if (cack) begin
      m_cons = m_cons - FUS + int'(xfer);
      m_send = 0;
    end else begin
      m_cons += int'(xfer);
    end
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din = '0;
    bus.ack_user2interface = 1'b0;
    bus.credit_out_ack = 1'b0;
    #1;
    chk("rst_vld", PB'(bus.vld_interface2user), '0);
    chk("rst_dout", PB'(bus.dout_leaf_interface2user), '0);
    chk("rst_credit_vld", PB'(bus.credit_out_vld), '0);
    chk("rst_credit_out", bus.credit_out, '0);
    chk("rst_overflow", PB'(overflow), '0);
    q.delete();
    m_send = 0; m_ovf = 0; m_cons = 0;
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    self_leaf = 6'd5;
    ctrl = {1'b1, src_leaf, src_port};
    din = '0;
    bus.ack_user2interface = 1'b0;
    bus.credit_out_ack = 1'b0;
    exp_credit = mk(1'b1, int'(src_leaf), int'(src_port), 1'b1, PW'(FUS));
    #1;
    do_reset();

    // Single packet latency
    while (cyc < 9) step('0, 0, 0);
    step(good(64'hDEAD), 0, 0);
    step('0, 0, 0);
    chk("lat_n1_vld", PB'(bus.vld_interface2user), '0);
    step('0, 0, 0);
    chk("lat_n2_vld", PB'(bus.vld_interface2user), PB'(1));
    chk("lat_n2_dout", PB'(bus.dout_leaf_interface2user), PB'(64'hDEAD));
    step('0, 1, 0);
    // Non-matching packets
    step(mk(1'b1, 5, 3, 1'b0, 64'h1111), 0, 0);
    step(mk(1'b1, 4, PORT, 1'b0, 64'h2222), 0, 0);
    step(mk(1'b1, 5, PORT, 1'b1, 64'h3333), 0, 0);
    step(mk(1'b0, 5, PORT, 1'b0, 64'h4444), 0, 0);
    repeat (3) step('0, 0, 0);
    chk("nomatch_vld", PB'(bus.vld_interface2user), '0);

    // Full FIFO with simultaneous write and transfer
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(good(PW'(i)), 0, 0);
    repeat (3) step('0, 0, 0);
    chk("full_no_ovf", PB'(overflow), '0);
    step(good(64'h999), 1, 0);
    chk("full_rw_ovf", PB'(overflow), '0);
    repeat (DEPTH) step('0, 1, 0);
    step('0, 1, 0);
    chk("full_rw_drained", PB'(bus.vld_interface2user), '0);

    // Overflow drop and in-order drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(good(PW'(i)), 0, 0);
    step(good(64'hBAD), 0, 0);
    chk("ovf_set", PB'(overflow), PB'(1));
    repeat (3) step('0, 0, 0);
    repeat (DEPTH) step('0, 1, 0);
    chk("ovf_drained", PB'(bus.vld_interface2user), '0);
    chk("ovf_sticky", PB'(overflow), PB'(1));

    // Credit generation, hold, ack, coincident ack
    do_reset();
    for (int i = 0; i < 70; i++) step(good(PW'(i + 1000)), 0, 0);
    repeat (63) step('0, 1, 0);
    chk("credit_pre", PB'(bus.credit_out_vld), '0);
    step('0, 1, 0);
    chk("credit_rise", PB'(bus.credit_out_vld), PB'(1));
    chk("credit_pkt", bus.credit_out, exp_credit);
    saved = bus.credit_out;
    for (int i = 0; i < 5; i++) begin
      step('0, 0, 0);
      chk("credit_hold", bus.credit_out, saved);
    end
    step('0, 0, 1);
    chk("credit_acked", PB'(bus.credit_out_vld), '0);
    for (int i = 0; i < 64; i++) step(good(PW'(i + 2000)), 1, 0);
    chk("credit2_rise", PB'(bus.credit_out_vld), PB'(1));
    step(good(64'h77), 1, 1);
    chk("credit_coinc", PB'(bus.credit_out_vld), '0);
    for (int i = 0; i < 62; i++) step(good(PW'(i + 3000)), 1, 0);
    chk("credit3_pre", PB'(bus.credit_out_vld), '0);
    step(good(64'h78), 1, 0);
    chk("credit3_rise", PB'(bus.credit_out_vld), PB'(1));
    step('0, 0, 1);

    // enable=0 blocks accepts but data drains
    en = 0;
    repeat (4) step(good(64'h5A5A), 1, 0);
    en = 1;

    // Reset while sending with 10 words buffered
    do_reset();
    for (int i = 0; i < 74; i++) step(good(PW'(i)), 0, 0);
    repeat (64) step('0, 1, 0);
    chk("mid_send_cvld", PB'(bus.credit_out_vld), PB'(1));
    chk("mid_send_vld", PB'(bus.vld_interface2user), PB'(1));
    do_reset();
    step(good(64'hBEEF), 0, 0);
    step('0, 0, 0);
    chk("post_rst_n1", PB'(bus.vld_interface2user), '0);
    step('0, 0, 0);
    chk("post_rst_vld", PB'(bus.vld_interface2user), PB'(1));
    chk("post_rst_dout", PB'(bus.dout_leaf_interface2user), PB'(64'hBEEF));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int mode;
      bit ack, cack;
      logic [PW-1:0] pl;
      mode = (i / 250) % 3;
      en = ($urandom % 8) != 0;
      pl = {$urandom, $urandom};
      ack = (mode == 0) ? (($urandom % 8) == 0) :
            (mode == 1) ? (($urandom % 2) == 0) : (($urandom % 8) != 0);
      cack = ($urandom % 4) == 0;
      step(mk(($urandom % 4) != 0,
              (($urandom % 4) != 0) ? 5 : int'($urandom % 64),
              (($urandom % 4) != 0) ? PORT : int'($urandom % 16),
              ($urandom % 8) == 0, pl), ack, cack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
